// File: rtl/neonfox_dcache.sv
// neonfox_dcache: direct-mapped, write-through, no-write-allocate data cache for the NeonFox
// CPU data port. Loads hit with zero latency. A load miss fills the whole line with single-word
// SDRAM reads. Stores are accepted into a one-entry write buffer that is drained to SDRAM. If a
// store hits, it also updates the cached word.
//
// Ports:
//   clk, reset_n           core clock, asynchronous active-low reset
//   data_address           CPU word address
//   data_out               CPU store data
//   data_ren, data_wren    CPU load / store requests
//   H_en, L_en             store byte enables (high / low byte)
//   data_in                load data (combinational, valid on hit)
//   d_cache_read_miss      load stall
//   d_cache_write_miss     store stall
//   mem_req/we/addr/wdata/be  registered SDRAM request, held until mem_ack
//   mem_ack, mem_rdata     SDRAM completion pulse and read data
module neonfox_dcache #(
  parameter int unsigned INDEX_BITS  = 8,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_address,
  input  logic [15:0] data_out,
  input  logic        data_ren,
  input  logic        data_wren,
  input  logic        H_en,
  input  logic        L_en,
  output logic [15:0] data_in,
  output logic        d_cache_read_miss,
  output logic        d_cache_write_miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << (INDEX_BITS + OFFSET_BITS);

  typedef enum logic [1:0] {StIdle, StWb, StFill} state_t;

  state_t r_state, w_state_next;

  logic [TAG_BITS-1:0] r_tag_mem  [LINES];
  logic [15:0]         r_data_mem [WORDS];
  logic [LINES-1:0]    r_valid;

  logic                r_wb_valid;
  logic [31:0]         r_wb_addr;
  logic [15:0]         r_wb_data;
  logic [1:0]          r_wb_be;

  logic [TAG_BITS-1:0]    r_fill_tag;
  logic [INDEX_BITS-1:0]  r_fill_index;
  logic [OFFSET_BITS-1:0] r_cnt;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [1:0]  r_mem_be;

  logic [OFFSET_BITS-1:0]            w_offset;
  logic [INDEX_BITS-1:0]             w_index;
  logic [TAG_BITS-1:0]               w_tag;
  logic [INDEX_BITS+OFFSET_BITS-1:0] w_word_addr;
  logic                              w_hit;
  logic                              w_write_busy;
  logic                              w_store_accept;
  logic                              w_fill_start;
  logic                              w_fill_ack;
  logic                              w_fill_last;

  assign w_offset    = data_address[OFFSET_BITS-1:0];
  assign w_index     = data_address[OFFSET_BITS +: INDEX_BITS];
  assign w_tag       = data_address[31 -: TAG_BITS];
  assign w_word_addr = {w_index, w_offset};

  assign w_hit   = r_valid[w_index] & (r_tag_mem[w_index] == w_tag);
  assign data_in = r_data_mem[w_word_addr];

  assign w_write_busy   = r_wb_valid | (r_state != StIdle);
  assign w_store_accept = data_wren & ~w_write_busy;
  // A concurrent store wins, so the load waits even on a hit; no fill starts while a store is
  // being accepted, which keeps the buffered store ahead of any later line fill.
  assign w_fill_start   = (r_state == StIdle) & ~r_wb_valid & data_ren & ~data_wren & ~w_hit;
  assign w_fill_ack     = (r_state == StFill) & r_mem_req & mem_ack;
  assign w_fill_last    = w_fill_ack & (&r_cnt);

  assign d_cache_read_miss  = reset_n & data_ren & (~w_hit | (r_state == StFill) | data_wren);
  assign d_cache_write_miss = reset_n & data_wren & w_write_busy;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (r_wb_valid) begin
          w_state_next = StWb;
        end else if (w_fill_start) begin
          w_state_next = StFill;
        end
      end
      StWb: begin
        if (r_mem_req & mem_ack) begin
          w_state_next = StIdle;
        end
      end
      StFill: begin
        if (w_fill_last) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_valid      <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_wb_be      <= 2'b11;
      r_fill_tag   <= '0;
      r_fill_index <= '0;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= 2'b11;
    end else begin
      r_state <= w_state_next;

      if (w_store_accept) begin
        r_wb_valid <= 1'b1;
        r_wb_addr  <= data_address;
        r_wb_data  <= data_out;
        r_wb_be    <= {H_en, L_en};
      end

      unique case (r_state)
        StIdle: begin
          if (r_wb_valid) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wb_addr;
            r_mem_wdata <= r_wb_data;
            r_mem_be    <= r_wb_be;
          end else if (w_fill_start) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= {w_tag, w_index, {OFFSET_BITS{1'b0}}};
            r_mem_be     <= 2'b11;
            r_fill_tag   <= w_tag;
            r_fill_index <= w_index;
            r_cnt        <= '0;
            // Invalidate up front so a partially refilled line can never hit.
            r_valid[w_index] <= 1'b0;
          end
        end
        StWb: begin
          if (r_mem_req & mem_ack) begin
            r_mem_req  <= 1'b0;
            r_wb_valid <= 1'b0;
          end
        end
        StFill: begin
          if (r_mem_req & mem_ack) begin
            // Request drops for one cycle so an ack is never counted twice.
            r_mem_req <= 1'b0;
            r_cnt     <= r_cnt + OFFSET_BITS'(1);
            if (&r_cnt) begin
              r_valid[r_fill_index] <= 1'b1;
            end
          end else if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {r_fill_tag, r_fill_index, r_cnt};
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays: asynchronous read, synchronous write, no reset. Fill and store writes never
  // coincide because stores are only accepted while idle.
  always_ff @(posedge clk) begin
    if (w_fill_ack) begin
      r_data_mem[{r_fill_index, r_cnt}] <= mem_rdata;
    end else if (w_store_accept & w_hit) begin
      if (H_en) begin
        r_data_mem[w_word_addr][15:8] <= data_out[15:8];
      end
      if (L_en) begin
        r_data_mem[w_word_addr][7:0] <= data_out[7:0];
      end
    end
    if (w_fill_last) begin
      r_tag_mem[r_fill_index] <= r_fill_tag;
    end
  end

endmodule

// File: tb/tb_neonfox_dcache.sv
module tb_neonfox_dcache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_address;
  logic [15:0] data_out;
  logic        data_ren;
  logic        data_wren;
  logic        H_en;
  logic        L_en;
  logic [15:0] data_in;
  logic        d_cache_read_miss;
  logic        d_cache_write_miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;

  neonfox_dcache dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .data_address       (data_address),
    .data_out           (data_out),
    .data_ren           (data_ren),
    .data_wren          (data_wren),
    .H_en               (H_en),
    .L_en               (L_en),
    .data_in            (data_in),
    .d_cache_read_miss  (d_cache_read_miss),
    .d_cache_write_miss (d_cache_write_miss),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_be             (mem_be),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired before the required event (cycle %0d)", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } wr_t;

  logic [15:0] sdram [logic [31:0]];   // what SDRAM holds
  logic [15:0] arch  [logic [31:0]];   // what the CPU must observe
  wr_t         exp_wq[$];              // accepted stores, in order, not yet written
  logic [21:0] m_tag [256];
  bit          m_val [256];

  function automatic logic [15:0] dflt(input logic [31:0] a);
    return 16'hA000 + a[15:0] - 16'h0104;
  endfunction

  function automatic logic [15:0] sd_rd(input logic [31:0] a);
    return sdram.exists(a) ? sdram[a] : dflt(a);
  endfunction

  function automatic logic [15:0] arch_rd(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : dflt(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = o;
    if (be[1]) r[15:8] = n[15:8];
    if (be[0]) r[7:0] = n[7:0];
    return r;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_val[a[9:2]] && (m_tag[a[9:2]] == a[31:10]);
  endfunction

  // ---------------- SDRAM responder ----------------
  logic [31:0] rd_log[$];
  int          rd_acks = 0;
  int          last_rack_cyc = -1;
  int          last_wack_cyc = -1;
  logic [31:0] last_waddr = '0;
  logic [1:0]  last_wbe = '0;
  int          lat_cnt = 0;
  int          lat_tgt = 0;
  bit          prev_pend = 0;
  logic [51:0] sv_bus;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      mem_ack = 1'b0;
      prev_pend = 0;
      lat_cnt = 0;
    end else begin
      if (prev_pend) chk("bus_stable", {mem_req, mem_we, mem_be, mem_wdata, mem_addr}, sv_bus);
      if (mem_req) begin
        if (lat_cnt >= lat_tgt) begin
          mem_ack = 1'b1;
          lat_cnt = 0;
          lat_tgt = $urandom_range(0, 3);
          prev_pend = 0;
          if (mem_we) begin
            wr_t e;
            sdram[mem_addr] = merge(sd_rd(mem_addr), mem_wdata, mem_be);
            last_wack_cyc = cyc;
            last_waddr = mem_addr;
            last_wbe = mem_be;
            if (exp_wq.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL wb_unexpected: write to 0x%0h, required none pending", mem_addr);
            end else begin
              e = exp_wq.pop_front();
              chk("wb_addr", mem_addr, e.a);
              chk("wb_data", mem_wdata, e.d);
              chk("wb_be", mem_be, e.be);
            end
          end else begin
            mem_rdata = sd_rd(mem_addr);
            chk("rd_be", mem_be, 2'b11);
            rd_log.push_back(mem_addr);
            rd_acks++;
            last_rack_cyc = cyc;
          end
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 16'($urandom);
          lat_cnt++;
          prev_pend = 1;
          sv_bus = {1'b1, mem_we, mem_be, mem_wdata, mem_addr};
        end
      end else begin
        mem_ack = 1'b0;
        prev_pend = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_read_miss", d_cache_read_miss, 0);
      chk("rst_write_miss", d_cache_write_miss, 0);
    end else begin
      if (data_ren && !d_cache_read_miss) chk("load_data", data_in, arch_rd(data_address));
      if (data_wren && !d_cache_write_miss) begin
        wr_t e;
        arch[data_address] = merge(arch_rd(data_address), data_out, {H_en, L_en});
        e.a = data_address;
        e.d = data_out;
        e.be = {H_en, L_en};
        exp_wq.push_back(e);
      end
    end
  end

  // ---------------- drivers (start and end at posedge + 1) ----------------
  task automatic do_load(input logic [31:0] a, output logic [15:0] d, output logic fm,
                         output int acc);
    bit   done;
    logic exp_m;
    done = 0;
    d = 'x;
    fm = 1'b0;
    acc = -1;
    data_address = a;
    data_ren = 1'b1;
    data_wren = 1'b0;
    exp_m = !model_hit(a);
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (k == 0) begin
        fm = d_cache_read_miss;
        chk("load_first_miss", fm, exp_m);
      end
      if (!d_cache_read_miss) begin
        d = data_in;
        acc = cyc;
        done = 1;
      end
    end
    if (!done) fail("load_timeout");
    else begin
      m_val[a[9:2]] = 1;
      m_tag[a[9:2]] = a[31:10];
    end
    @(posedge clk);
    #1;
    data_ren = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [15:0] d, input logic [1:0] be,
                          output logic st, output int acc);
    bit done;
    done = 0;
    st = 1'b0;
    acc = -1;
    data_address = a;
    data_out = d;
    {H_en, L_en} = be;
    data_wren = 1'b1;
    data_ren = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (k == 0) st = d_cache_write_miss;
      if (!d_cache_write_miss) begin
        acc = cyc;
        done = 1;
      end
    end
    if (!done) fail("store_timeout");
    @(posedge clk);
    #1;
    data_wren = 1'b0;
  endtask

  task automatic wait_idle();
    int q;
    q = 0;
    for (int k = 0; k < 300 && q < 3; k++) begin
      @(negedge clk);
      if (!mem_req && exp_wq.size() == 0) q++;
      else q = 0;
    end
    if (q < 3) fail("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] d;
    logic        fm, st, st2;
    int          acc, acc2, base;
    bit          done;

    foreach (m_val[i]) m_val[i] = 0;
    reset_n = 1'b0;
    data_address = '0;
    data_out = '0;
    data_ren = 1'b1;
    data_wren = 1'b1;
    H_en = 1'b1;
    L_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 2'b11);
    reset_n = 1'b1;
    data_ren = 1'b0;
    data_wren = 1'b0;
    @(posedge clk);
    #1;

    // Cold load fills 0x104..0x107, miss clears the cycle after the 4th ack.
    rd_log.delete();
    do_load(32'h105, d, fm, acc);
    chk("cold_miss", fm, 1);
    chk("cold_data", d, 16'hA001);
    chk("cold_fill_words", rd_log.size(), 4);
    if (rd_log.size() == 4) for (int i = 0; i < 4; i++) chk("cold_fill_addr", rd_log[i], 32'h104 + i);
    chk("cold_miss_clear_cycle", acc, last_rack_cyc + 1);

    // Load hit: zero latency, no memory traffic.
    base = rd_acks;
    do_load(32'h106, d, fm, acc);
    chk("hit_miss", fm, 0);
    chk("hit_data", d, 16'hA002);
    chk("hit_no_mem_read", rd_acks, base);
    chk("hit_no_req", mem_req, 0);

    // High-byte store hit.
    do_store(32'h104, 16'h12FF, 2'b10, st, acc);
    chk("store_idle_stall", st, 0);
    do_load(32'h104, d, fm, acc);
    chk("store_hit_miss", fm, 0);
    chk("store_hit_data", d, 16'h1200);
    wait_idle();
    chk("store_wb_addr", last_waddr, 32'h104);
    chk("store_wb_be", last_wbe, 2'b10);
    chk("store_sdram", sd_rd(32'h104), 16'h1200);

    // Back-to-back store misses.
    do_store(32'h200, 16'h1111, 2'b11, st, acc);
    do_store(32'h201, 16'h2222, 2'b11, st2, acc2);
    chk("b2b_first_stall", st, 0);
    chk("b2b_second_stall", st2, 1);
    chk("b2b_accept_cycle", acc2, last_wack_cyc + 1);
    do_load(32'h200, d, fm, acc);
    chk("no_allocate_miss", fm, 1);
    chk("no_allocate_data", d, 16'h1111);

    // Store during an abandoned fill: fill completes, store waits for the first idle cycle.
    wait_idle();
    rd_log.delete();
    data_address = 32'h300;
    data_ren = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fill_miss_held", d_cache_read_miss, 1);
    end
    @(posedge clk);
    #1;
    data_ren = 1'b0;
    data_address = 32'h1234;
    data_out = 16'hBEEF;
    {H_en, L_en} = 2'b11;
    data_wren = 1'b1;
    done = 0;
    acc = -1;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (!d_cache_write_miss) begin
        acc = cyc;
        done = 1;
      end
    end
    if (!done) fail("fill_store_timeout");
    chk("fill_store_accept_cycle", acc, last_rack_cyc + 1);
    chk("fill_abandon_words", rd_log.size(), 4);
    @(posedge clk);
    #1;
    data_wren = 1'b0;
    m_val[8'hC0] = 1;
    m_tag[8'hC0] = 22'h0;
    wait_idle();
    chk("fill_store_wb_addr", last_waddr, 32'h1234);
    do_load(32'h300, d, fm, acc);
    chk("abandoned_fill_hit", fm, 0);
    chk("abandoned_fill_data", d, 16'hA1FC);

    // Concurrent load and store: the store wins, the load stalls that cycle.
    wait_idle();
    data_address = 32'h105;
    data_out = 16'h5A5A;
    {H_en, L_en} = 2'b11;
    data_ren = 1'b1;
    data_wren = 1'b1;
    @(negedge clk);
    chk("conc_read_miss", d_cache_read_miss, 1);
    chk("conc_write_miss", d_cache_write_miss, 0);
    @(posedge clk);
    #1;
    data_wren = 1'b0;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (!d_cache_read_miss) begin
        d = data_in;
        done = 1;
      end
    end
    if (!done) fail("conc_load_timeout");
    chk("conc_load_data", d, 16'h5A5A);
    @(posedge clk);
    #1;
    data_ren = 1'b0;

    // Reset in the middle of a fill.
    wait_idle();
    base = rd_acks;
    data_address = 32'h400;
    data_ren = 1'b1;
    done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (rd_acks - base >= 2 && rd_acks - base < 4 && mem_req) done = 1;
    end
    if (!done) begin
      fail("midfill_timeout");
    end else begin
      reset_n = 1'b0;
      #1;
      chk("midfill_rst_req", mem_req, 0);
      chk("midfill_rst_read_miss", d_cache_read_miss, 0);
    end
    foreach (m_val[i]) m_val[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    data_ren = 1'b0;
    rd_log.delete();
    @(posedge clk);
    #1;
    do_load(32'h400, d, fm, acc);
    chk("midfill_reload_miss", fm, 1);
    chk("midfill_reload_words", rd_log.size(), 4);
    if (rd_log.size() == 4) for (int i = 0; i < 4; i++) chk("midfill_reload_addr", rd_log[i], 32'h400 + i);
    chk("midfill_reload_data", d, 16'hA2FC);

    // Randomized traffic over a few conflicting lines.
    for (int n = 0; n < 300; n++) begin
      int unsigned t, ix, off;
      logic [31:0] a;
      t = $urandom_range(0, 2);
      ix = $urandom_range(0, 3);
      off = $urandom_range(0, 3);
      a = (t << 10) | (ix << 2) | off;
      if ($urandom_range(0, 9) < 6) do_load(a, d, fm, acc);
      else do_store(a, 16'($urandom), 2'($urandom_range(1, 3)), st, acc);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
